// File: rtl/debounce_sync_if.sv
// Signal bundle between a raw level source and the debounce_sync conditioner.
// The master drives the raw level; the slave (the debouncer) returns the clean level and strobes.
interface debounce_sync_if;
    logic d_in;
    logic q;
    logic rise;
    logic fall;
    logic busy;

    modport master (
        output d_in,
        input  q,
        input  rise,
        input  fall,
        input  busy
    );

    modport slave (
        input  d_in,
        output q,
        output rise,
        output fall,
        output busy
    );
endinterface

// File: rtl/debounce_sync.sv
// Two-flop synchroniser followed by a count-qualified debounce FSM; drives a clean
// registered level plus one-cycle rise/fall strobes for the downstream flip-flop stage.
module debounce_sync #(
    parameter int STABLE = 4,
    parameter int CW     = 8
) (
    input logic            clk,
    input logic            rst,
    debounce_sync_if.slave bus
);

    typedef enum logic [1:0] {
        LOW       = 2'd0,
        RISE_WAIT = 2'd1,
        HIGH      = 2'd2,
        FALL_WAIT = 2'd3
    } state_t;

    localparam logic [CW-1:0] LAST = CW'(STABLE - 1);

    logic          s1;
    logic          s;
    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic          rise_nxt;
    logic          fall_nxt;
    logic          q_r;
    logic          rise_r;
    logic          fall_r;
    logic          busy_r;

    // Only s1 may go metastable; s gives it a full cycle to settle.
    // NOTE: flops use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1 <= 1'b0;
            s  <= 1'b0;
        end else begin
            s1 <= bus.d_in;
            s  <= s1;
        end
    end

    always_comb begin
        // NOTE: defaults first, so no branch below can leave a signal unassigned and infer a latch.
        state_nxt = state;
        cnt_nxt   = cnt;
        rise_nxt  = 1'b0;
        fall_nxt  = 1'b0;
        case (state)
            LOW: begin
                if (s) begin
                    if (STABLE == 1) begin
                        state_nxt = HIGH;
                        rise_nxt  = 1'b1;
                    end else begin
                        state_nxt = RISE_WAIT;
                        cnt_nxt   = CW'(1);
                    end
                end
            end
            RISE_WAIT: begin
                if (!s) begin
                    state_nxt = LOW;
                    cnt_nxt   = '0;
                end else if (cnt == LAST) begin
                    state_nxt = HIGH;
                    cnt_nxt   = '0;
                    rise_nxt  = 1'b1;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            HIGH: begin
                if (!s) begin
                    if (STABLE == 1) begin
                        state_nxt = LOW;
                        fall_nxt  = 1'b1;
                    end else begin
                        state_nxt = FALL_WAIT;
                        cnt_nxt   = CW'(1);
                    end
                end
            end
            FALL_WAIT: begin
                if (s) begin
                    state_nxt = HIGH;
                    cnt_nxt   = '0;
                end else if (cnt == LAST) begin
                    state_nxt = LOW;
                    cnt_nxt   = '0;
                    fall_nxt  = 1'b1;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            default: begin
                state_nxt = LOW;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state and registered, so they are glitch-free
    // and aligned with the state they describe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: every register, synchroniser included, is cleared so a pending transition dies with reset.
            state  <= LOW;
            cnt    <= '0;
            q_r    <= 1'b0;
            rise_r <= 1'b0;
            fall_r <= 1'b0;
            busy_r <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            q_r    <= (state_nxt == HIGH) || (state_nxt == FALL_WAIT);
            rise_r <= rise_nxt;
            fall_r <= fall_nxt;
            busy_r <= (state_nxt == RISE_WAIT) || (state_nxt == FALL_WAIT);
        end
    end

    assign bus.q    = q_r;
    assign bus.rise = rise_r;
    assign bus.fall = fall_r;
    assign bus.busy = busy_r;

endmodule

// File: tb/tb_debounce_sync.sv
// Bench for debounce_sync: STABLE=4 and STABLE=1 instances share one raw input and are
// checked against fixed vectors, hand sequences, and a sample-window reference model.
module tb_debounce_sync;

    typedef struct {
        logic       d;
        logic [3:0] exp;   // {q, rise, fall, busy}
    } vec_t;

    logic clk  = 1'b0;
    logic rst  = 1'b1;
    logic d_in = 1'b0;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : inst
        localparam int ST = (g == 0) ? 4 : 1;

        debounce_sync_if bus ();
        assign bus.d_in = d_in;

        debounce_sync #(.STABLE(ST), .CW(8)) dut (
            .clk (clk),
            .rst (rst),
            .bus (bus)
        );

        logic [3:0] act;
        assign act = {bus.q, bus.rise, bus.fall, bus.busy};

        // Reference: q flips once the last ST levels seen by the qualifier all differ from q.
        bit s1_m = 1'b0;
        bit s_m  = 1'b0;
        bit q_m  = 1'b0;
        bit rise_m = 1'b0;
        bit fall_m = 1'b0;
        bit busy_m = 1'b0;
        bit obs[$];
        logic [3:0] mdl;
        assign mdl = {q_m, rise_m, fall_m, busy_m};

        always @(posedge clk or negedge rst) begin
            if (!rst) begin
                s1_m = 1'b0; s_m = 1'b0; q_m = 1'b0;
                rise_m = 1'b0; fall_m = 1'b0; busy_m = 1'b0;
                obs.delete();
            end else begin
                bit all_diff;
                obs.push_front(s_m);
                if (obs.size() > 32) void'(obs.pop_back());
                s_m  = s1_m;
                s1_m = d_in;
                all_diff = (obs.size() >= ST);
                for (int i = 0; i < ST && all_diff; i++)
                    if (obs[i] == q_m) all_diff = 1'b0;
                rise_m = all_diff && !q_m;
                fall_m = all_diff && q_m;
                if (all_diff) q_m = !q_m;
                busy_m = (obs[0] != q_m);
            end
        end
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic step(input logic d);
        @(negedge clk);
        d_in = d;
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[$];

    function automatic void add(input logic d, input logic [3:0] exp);
        vec_t v;
        v.d = d;
        v.exp = exp;
        vecs.push_back(v);
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Clean step up and back down.
        add(1, 4'b0000); add(1, 4'b0000); add(1, 4'b0001); add(1, 4'b0001);
        add(1, 4'b0001); add(1, 4'b1100); add(1, 4'b1000);
        add(0, 4'b1000); add(0, 4'b1000); add(0, 4'b1001); add(0, 4'b1001);
        add(0, 4'b1001); add(0, 4'b0010); add(0, 4'b0000); add(0, 4'b0000);
        add(0, 4'b0000);
        // Three-cycle glitch is rejected.
        add(1, 4'b0000); add(1, 4'b0000); add(1, 4'b0001); add(0, 4'b0001);
        add(0, 4'b0001); add(0, 4'b0000); add(0, 4'b0000);
        // Four-cycle pulse is accepted, then released.
        add(1, 4'b0000); add(1, 4'b0000); add(1, 4'b0001); add(1, 4'b0001);
        add(0, 4'b0001); add(0, 4'b1100); add(0, 4'b1001); add(0, 4'b1001);
        add(0, 4'b1001); add(0, 4'b0010); add(0, 4'b0000);
        // Bounce 1,0,1,1,0,1,1,1,1 then hold.
        add(1, 4'b0000); add(0, 4'b0000); add(1, 4'b0001); add(1, 4'b0000);
        add(0, 4'b0001); add(1, 4'b0001); add(1, 4'b0000); add(1, 4'b0001);
        add(1, 4'b0001); add(1, 4'b0001); add(1, 4'b1100); add(1, 4'b1000);
        add(0, 4'b1000); add(0, 4'b1000); add(0, 4'b1001); add(0, 4'b1001);
        add(0, 4'b1001); add(0, 4'b0010); add(0, 4'b0000);

        // Reset held with d_in high: everything stays clear.
        #1 rst = 1'b0;
        d_in = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            check($sformatf("rst_hold4_%0d", c), {4'b0, inst[0].act}, 8'h00);
            check($sformatf("rst_hold1_%0d", c), {4'b0, inst[1].act}, 8'h00);
        end
        @(negedge clk);
        rst = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            @(posedge clk); #1;
            check($sformatf("rel4_e%0d", e), {4'b0, inst[0].act},
                  {4'b0, (e >= 6), (e == 6), 1'b0, (e >= 3 && e <= 5)});
            check($sformatf("rel1_e%0d", e), {4'b0, inst[1].act},
                  {4'b0, (e >= 3), (e == 3), 2'b00});
        end
        for (int c = 0; c < 10; c++) begin
            step(0);
            check($sformatf("settle_%0d", c), {4'b0, inst[0].act}, {4'b0, inst[0].mdl});
        end

        foreach (vecs[i]) begin
            step(vecs[i].d);
            check($sformatf("vec%0d", i), {4'b0, inst[0].act}, {4'b0, vecs[i].exp});
        end

        // Reset while qualifying a rise with cnt=2.
        for (int c = 0; c < 4; c++) step(1);
        check("mid_cnt", inst[0].dut.cnt, 8'd2);
        check("mid_busy", {4'b0, inst[0].act}, 8'h01);
        #2 rst = 1'b0;
        #1;
        check("mid_rst_out", {4'b0, inst[0].act}, 8'h00);
        check("mid_rst_cnt", inst[0].dut.cnt, 8'd0);
        d_in = 1'b0;
        @(negedge clk); @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 8; c++) begin
            step(0);
            check($sformatf("mid_after_%0d", c), {4'b0, inst[0].act}, 8'h00);
        end

        // Reset while HIGH: q drops with no fall strobe.
        for (int c = 0; c < 7; c++) step(1);
        check("high_before", {4'b0, inst[0].act}, 8'h08);
        #2 rst = 1'b0;
        #1;
        check("high_rst_out", {4'b0, inst[0].act}, 8'h00);
        d_in = 1'b0;
        @(negedge clk); @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 8; c++) begin
            step(0);
            check($sformatf("high_after_%0d", c), {4'b0, inst[0].act}, 8'h00);
        end

        // STABLE=1: clean step, then a single-cycle pulse.
        step(1); check("s1_up_k0", {4'b0, inst[1].act}, 8'h00);
        step(1); check("s1_up_k1", {4'b0, inst[1].act}, 8'h00);
        step(1); check("s1_up_k2", {4'b0, inst[1].act}, 8'h0C);
        step(1); check("s1_up_k3", {4'b0, inst[1].act}, 8'h08);
        step(0); check("s1_dn_k0", {4'b0, inst[1].act}, 8'h08);
        step(0); check("s1_dn_k1", {4'b0, inst[1].act}, 8'h08);
        step(0); check("s1_dn_k2", {4'b0, inst[1].act}, 8'h02);
        step(0); check("s1_dn_k3", {4'b0, inst[1].act}, 8'h00);
        step(1); check("s1_pl_k0", {4'b0, inst[1].act}, 8'h00);
        step(0); check("s1_pl_k1", {4'b0, inst[1].act}, 8'h00);
        step(0); check("s1_pl_k2", {4'b0, inst[1].act}, 8'h0C);
        step(0); check("s1_pl_k3", {4'b0, inst[1].act}, 8'h02);
        step(0); check("s1_pl_k4", {4'b0, inst[1].act}, 8'h00);

        // Random runs of random length against the reference model.
        for (int r = 0; r < 150; r++) begin
            logic lvl;
            int   len;
            lvl = 1'($urandom_range(0, 1));
            len = int'($urandom_range(1, 7));
            for (int c = 0; c < len; c++) begin
                step(lvl);
                check("rand4", {4'b0, inst[0].act}, {4'b0, inst[0].mdl});
                check("rand1", {4'b0, inst[1].act}, {4'b0, inst[1].mdl});
            end
            if ($urandom_range(0, 30) == 0) begin
                #2 rst = 1'b0;
                #1;
                check("rand_rst4", {4'b0, inst[0].act}, 8'h00);
                check("rand_rst1", {4'b0, inst[1].act}, 8'h00);
                #2 rst = 1'b1;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/debounce_sync.md
# debounce_sync

Input conditioning stage placed directly upstream of the team's D flip-flop stage. It takes a raw, asynchronous, bouncy level, such as a push-button or switch. It synchronises that level into the `clk` domain, rejects pulses shorter than a programmable number of cycles, and drives a clean debounced level `q` that feeds the flip-flop's `d` input. It also produces single-cycle `rise` and `fall` strobes for downstream control logic.

## Interface
- `STABLE`, default 4: number of consecutive synchronised samples that must differ from `q` before `q` toggles. Legal range is 1 to 2^`CW`-1.
- `CW`, default 8: width of the stability counter.
- `clk`  input  1  rising-edge clock.
- `rst`  input  1  asynchronous, active-low reset. Asserting it (0) immediately forces all state; release is sampled on `clk`.
- `d_in`  input  1  raw asynchronous level. It may change at any time relative to `clk`.
- `q`  output  1  debounced, registered level.
- `rise`  output  1  one-cycle pulse, high in the cycle `q` goes 0→1.
- `fall`  output  1  one-cycle pulse, high in the cycle `q` goes 1→0.
- `busy`  output  1  high while a candidate transition is being qualified, i.e. in the RISE_WAIT or FALL_WAIT state.

## Operation
- **Synchroniser:** two flops, `d_in` → `s1` → `s`. Only `s` is used by the rest of the block.
- **State machine:** states LOW, RISE_WAIT, HIGH, FALL_WAIT.
  - `q`=1 exactly when the state is HIGH or FALL_WAIT.
  - `busy`=1 exactly when the state is RISE_WAIT or FALL_WAIT.
- **LOW:**
  - `s`=0: stay in LOW.
  - `s`=1 and `STABLE`=1: go to HIGH and pulse `rise`.
  - `s`=1 and `STABLE`>1: go to RISE_WAIT with `cnt`=1.
- **RISE_WAIT:**
  - `s`=0: go to LOW, `cnt`=0. The glitch is rejected and no strobe is produced.
  - `s`=1 and `cnt`=`STABLE`-1: go to HIGH, `cnt`=0, pulse `rise`.
  - Otherwise: `cnt`+1.
- **HIGH / FALL_WAIT:** mirror of LOW / RISE_WAIT with `s` inverted, pulsing `fall`.
- **Counter:** `cnt` is `CW` bits and never exceeds `STABLE`-1, so it cannot wrap. `cnt`=0 whenever the state is LOW or HIGH.
- **Strobes:** `rise` and `fall` are registered, never both high in the same cycle, and always high for exactly one cycle per accepted transition.
- **Reset:** while `rst`=0, the following values are forced asynchronously and held:
  - `s1`=0, `s`=0
  - state=LOW, `cnt`=0
  - `q`=0, `rise`=0, `fall`=0, `busy`=0
- **Reset mid-qualification:** a pending transition is discarded and no strobe is produced.
- **Reset while HIGH:** `q` drops to 0 with no `fall` strobe.

## Timing
- Let E0 be the first `clk` edge that samples the new `d_in` value into `s1`.
  - `s` changes at E1.
  - The state machine first observes the change at E2.
  - `q` and the strobe update at edge E(`STABLE`+1), provided `s` holds its new value for `STABLE` consecutive edges, E2 through E(`STABLE`+1).
- Total latency from `d_in` change to `q` is therefore `STABLE`+1 edges after E0. With `STABLE`=4, `q` changes 5 edges after E0.
- A synchronised pulse lasting N cycles is:
  - accepted when N ≥ `STABLE`;
  - rejected when N < `STABLE`. The state machine then returns to its stable state the edge after `s` reverts, with `busy` high for N cycles.
- Bounce inside a wait state restarts qualification from `cnt`=0. There is no hysteresis beyond the count.
- Metastability: only `s1` may go metastable. `s1` gets a full cycle to resolve before `s` is used.

## Test plan
- **Reset:** hold `rst`=0 with `d_in`=1 for 3 cycles → `q`=0, `rise`=0, `fall`=0, `busy`=0 throughout. After release, `q` rises at the 6th edge after release (first sample at the 1st edge, accepted at the 6th), with `rise` high for exactly that one cycle.
- **Clean step, `STABLE`=4:** `d_in` 0→1 between edges → `busy` high for 3 cycles, then `q`=1 and `rise`=1 for one cycle at E5. Drive `d_in` 1→0 → `fall` pulse one cycle, `q`=0, 5 edges after its first sample.
- **Glitch rejection:** `d_in` high for 3 clock cycles, then low → `q` stays 0, no `rise`, `busy` high for 3 cycles then 0. Repeat with a 4-cycle pulse → `q`=1 and `rise` pulses once.
- **Bounce:** toggle `d_in` 1,0,1,1,0,1,1,1,1 cycle by cycle → `q` rises only after the final run of 4 highs, with exactly one `rise` pulse.
- **Reset mid-operation:** assert `rst` while in RISE_WAIT with `cnt`=2 → `busy`, `cnt` and `q` clear immediately and no `rise` occurs. Repeat with `rst` asserted while in HIGH → `q`=0 with no `fall` pulse.
- **`STABLE`=1 instance:** `d_in` 0→1 → `q` rises 2 edges after E0 and `busy` never asserts. A 1-cycle pulse is accepted, producing a `rise` then a `fall`, each lasting one cycle.
